// File: rtl/controle.sv
// controle: control block (BC) for the operativo datapath (BO).
// A Moore FSM sequences the datapath muxes, ULA operation and register loads to
// evaluate one of four modo-selected expressions over X, A, B and C; the result
// ends up in the datapath RegS and a one-cycle pronto pulse marks completion.
//   modo 00: A*X*X + B*X + C  (computed as (A*X + B)*X + C)
//   modo 01: A*X + B
//   modo 10: X*X
//   modo 11: A + B + C
// Optional feature macro: CTRL_OVF_EN registers the datapath overflow flag into
// erro at the end of each run. Without it erro is tied 0.
module controle #(
    parameter logic H_MUL = 1'b1   // h value selecting multiply; add is ~H_MUL
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       inicio,
    input  logic [1:0] modo,
    input  logic       overflow,
    output logic       lx,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       h,
    output logic       lh,
    output logic       ls,
    output logic       pronto,
    output logic       ocupado,
    output logic       erro
);

    localparam logic H_ADD = ~H_MUL;

    // Mux encodings, named after the datapath sources they select.
    localparam logic [1:0] M0_ZERO = 2'b00;
    localparam logic [1:0] M0_A    = 2'b01;
    localparam logic [1:0] M0_B    = 2'b10;
    localparam logic [1:0] M0_C    = 2'b11;

    localparam logic [1:0] M1_OUTM0 = 2'b00;
    localparam logic [1:0] M1_REGX  = 2'b01;
    localparam logic [1:0] M1_REGH  = 2'b11;

    localparam logic [1:0] M2_REGX  = 2'b00;
    localparam logic [1:0] M2_OUTM0 = 2'b01;
    localparam logic [1:0] M2_REGH  = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        LOADX,
        MUL_AX,
        ADD_B,
        MUL_HX,
        ADD_C_S,
        ADD_B_S,
        SQR_S,
        CLR,
        ADD_A,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] modo_r;
    logic       accept;

    // A run starts only when IDLE sees inicio; modo is captured at that moment.
    assign accept = (state == IDLE) && inicio;

    // State register and captured operation; reset aborts any run at once.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            modo_r <= 2'b00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register updates from the pre-edge values, independent of order.
            state <= state_next;
            if (accept) begin
                modo_r <= modo;
            end
        end
    end

    // Next-state and Moore output decode from the state register.
    always_comb begin
        // NOTE: every output and the next state get a default first so no path
        // through the case leaves a variable unassigned (which would infer a latch).
        state_next = state;
        lx         = 1'b0;
        m0         = M0_ZERO;
        m1         = M1_OUTM0;
        m2         = M2_REGX;
        h          = H_ADD;
        lh         = 1'b0;
        ls         = 1'b0;
        pronto     = 1'b0;

        case (state)
            IDLE: begin
                if (inicio) begin
                    state_next = LOADX;
                end
            end

            LOADX: begin
                lx = 1'b1;
                case (modo_r)
                    2'b10:   state_next = SQR_S;
                    2'b11:   state_next = CLR;
                    default: state_next = MUL_AX;
                endcase
            end

            // H = A * X
            MUL_AX: begin
                m0 = M0_A;
                m1 = M1_OUTM0;
                m2 = M2_REGX;
                h  = H_MUL;
                lh = 1'b1;
                state_next = (modo_r == 2'b01) ? ADD_B_S : ADD_B;
            end

            // H = B + H
            ADD_B: begin
                m0 = M0_B;
                m1 = M1_OUTM0;
                m2 = M2_REGH;
                lh = 1'b1;
                state_next = (modo_r == 2'b00) ? MUL_HX : ADD_C_S;
            end

            // H = H * X
            MUL_HX: begin
                m0 = M0_ZERO;
                m1 = M1_REGH;
                m2 = M2_REGX;
                h  = H_MUL;
                lh = 1'b1;
                state_next = ADD_C_S;
            end

            // S = C + H (final step of modo 00 and 11)
            ADD_C_S: begin
                m0 = M0_C;
                m1 = M1_OUTM0;
                m2 = M2_REGH;
                ls = 1'b1;
                state_next = DONE;
            end

            // S = B + H (final step of modo 01)
            ADD_B_S: begin
                m0 = M0_B;
                m1 = M1_OUTM0;
                m2 = M2_REGH;
                ls = 1'b1;
                state_next = DONE;
            end

            // S = X * X (only step of modo 10)
            SQR_S: begin
                m0 = M0_ZERO;
                m1 = M1_REGX;
                m2 = M2_REGX;
                h  = H_MUL;
                ls = 1'b1;
                state_next = DONE;
            end

            // H = 0 + 0, so the A + B + C chain starts from a clean accumulator
            CLR: begin
                m0 = M0_ZERO;
                m1 = M1_OUTM0;
                m2 = M2_OUTM0;
                lh = 1'b1;
                state_next = ADD_A;
            end

            // H = A + H
            ADD_A: begin
                m0 = M0_A;
                m1 = M1_OUTM0;
                m2 = M2_REGH;
                lh = 1'b1;
                state_next = ADD_B;
            end

            DONE: begin
                pronto     = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ocupado = (state != IDLE);

`ifdef CTRL_OVF_EN
    logic erro_r;

    // Capture the datapath overflow at the end of a run; clear when a new run starts.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            erro_r <= 1'b0;
        end else if (accept) begin
            erro_r <= 1'b0;
        end else if (state == DONE) begin
            erro_r <= overflow;
        end
    end

    assign erro = erro_r;
`else
    // Overflow reporting is compiled out; the input is deliberately left unused.
    logic unused_overflow;
    assign unused_overflow = overflow;
    assign erro            = 1'b0;
`endif

endmodule
